// File: rtl/sop_result_accumulator.sv
// rtl/sop_result_accumulator.sv - saturating dot-product accumulator for the int_sop_2 result stream
// Sums LEN signed terms per window and parks the clamped total in a one-entry valid/ready register.
module sop_result_accumulator #(
  parameter int IN_W  = 37,
  parameter int ACC_W = 48,
  parameter int LEN   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_sat,
  output logic [15:0]      term_cnt
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  localparam logic [15:0]      LAST_CNT = 16'(LEN - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [15:0]      r_term_cnt;
  logic             r_sat_sticky;
  logic [ACC_W-1:0] r_out_data;
  logic             r_out_sat;

  logic [ACC_W:0]   w_term_ext;
  logic [ACC_W:0]   w_acc_ext;
  logic [ACC_W:0]   w_sum;
  logic             w_clamp;
  logic [ACC_W-1:0] w_sum_sat;
  logic             w_accept;
  logic             w_last;
  logic             w_complete;

  assign out_valid  = (r_state == S_FULL);
  assign in_ready   = !out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_last     = (r_term_cnt == LAST_CNT);
  assign w_complete = w_accept && w_last && !flush;

  assign w_term_ext = {{(ACC_W + 1 - IN_W){in_data[IN_W-1]}}, in_data};
  assign w_acc_ext  = {r_acc[ACC_W-1], r_acc};
  assign w_sum      = w_term_ext + w_acc_ext;
  // The two top bits disagree only when the true sum left the ACC_W range.
  assign w_clamp    = w_sum[ACC_W] ^ w_sum[ACC_W-1];
  assign w_sum_sat  = !w_clamp ? w_sum[ACC_W-1:0] : (w_sum[ACC_W] ? ACC_MIN : ACC_MAX);

  assign out_data = r_out_data;
  assign out_sat  = r_out_sat;
  assign term_cnt = r_term_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_EMPTY;
      r_acc        <= '0;
      r_term_cnt   <= '0;
      r_sat_sticky <= 1'b0;
      r_out_data   <= '0;
      r_out_sat    <= 1'b0;
    end else begin
      if (flush) begin
        r_acc        <= '0;
        r_term_cnt   <= '0;
        r_sat_sticky <= 1'b0;
      end else if (w_accept) begin
        if (w_last) begin
          r_acc        <= '0;
          r_term_cnt   <= '0;
          r_sat_sticky <= 1'b0;
        end else begin
          r_acc        <= w_sum_sat;
          r_term_cnt   <= r_term_cnt + 16'd1;
          r_sat_sticky <= r_sat_sticky | w_clamp;
        end
      end

      // A completion in the same cycle as a handshake overwrites the drained result.
      if (w_complete) begin
        r_out_data <= w_sum_sat;
        r_out_sat  <= r_sat_sticky | w_clamp;
      end

      case (r_state)
        S_EMPTY: if (w_complete) r_state <= S_FULL;
        S_FULL:  if (out_ready && !w_complete) r_state <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_sop_result_accumulator.sv
// tb/tb_sop_result_accumulator.sv - scoreboard bench for sop_result_accumulator
// Four instances cover LEN=4 at ACC_W 48/40/38 and LEN=1 at ACC_W 48.
module tb_sop_result_accumulator;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic [N-1:0]         in_valid;
  logic [N-1:0]         flush_s;
  logic [N-1:0]         out_ready;
  logic [N-1:0][36:0]   in_data;
  wire  [N-1:0]         in_ready;
  wire  [N-1:0]         out_valid;
  wire  [N-1:0]         out_sat;
  wire  [N-1:0][15:0]   tc;
  wire  [47:0]          od0;
  wire  [39:0]          od1;
  wire  [37:0]          od2;
  wire  [47:0]          od3;
  logic [47:0]          ox [N];

  always_comb begin
    ox[0] = od0;
    ox[1] = {{8{od1[39]}}, od1};
    ox[2] = {{10{od2[37]}}, od2};
    ox[3] = od3;
  end

  sop_result_accumulator #(.IN_W(37), .ACC_W(48), .LEN(4)) u_a48 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_data(in_data[0]), .in_ready(in_ready[0]),
    .flush(flush_s[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(od0),
    .out_sat(out_sat[0]), .term_cnt(tc[0]));
  sop_result_accumulator #(.IN_W(37), .ACC_W(40), .LEN(4)) u_a40 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_data(in_data[1]), .in_ready(in_ready[1]),
    .flush(flush_s[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(od1),
    .out_sat(out_sat[1]), .term_cnt(tc[1]));
  sop_result_accumulator #(.IN_W(37), .ACC_W(38), .LEN(4)) u_a38 (
    .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_data(in_data[2]), .in_ready(in_ready[2]),
    .flush(flush_s[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(od2),
    .out_sat(out_sat[2]), .term_cnt(tc[2]));
  sop_result_accumulator #(.IN_W(37), .ACC_W(48), .LEN(1)) u_l1 (
    .clk(clk), .reset(reset), .in_valid(in_valid[3]), .in_data(in_data[3]), .in_ready(in_ready[3]),
    .flush(flush_s[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]), .out_data(od3),
    .out_sat(out_sat[3]), .term_cnt(tc[3]));

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int          k;
    logic [47:0] d;
    logic        s;
  } exp_t;
  exp_t sb[$];

  int     lens [N] = '{4, 4, 4, 1};
  int     accw [N] = '{48, 40, 38, 48};
  longint m_acc [N];
  int     m_cnt [N];
  bit     m_sat [N];

  localparam longint P36M1 = 64'sd68719476735;
  localparam longint N36   = -64'sd68719476736;

  function automatic logic [47:0] s48(input longint v);
    return v[47:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      m_acc[k] = 0;
      m_cnt[k] = 0;
      m_sat[k] = 1'b0;
    end
  endtask

  // Reference accumulate/clamp; pushes the expected result when a window completes.
  task automatic model_accept(input int k, input longint term, input bit fl);
    longint hi, lo, sum;
    bit     clamp;
    exp_t   e;
    if (fl) begin
      m_acc[k] = 0;
      m_cnt[k] = 0;
      m_sat[k] = 1'b0;
      return;
    end
    hi    = (longint'(1) <<< (accw[k] - 1)) - 1;
    lo    = -hi - 1;
    sum   = m_acc[k] + term;
    clamp = 1'b0;
    if (sum > hi) begin sum = hi; clamp = 1'b1; end
    else if (sum < lo) begin sum = lo; clamp = 1'b1; end
    if (m_cnt[k] == lens[k] - 1) begin
      e.k = k;
      e.d = s48(sum);
      e.s = m_sat[k] | clamp;
      sb.push_back(e);
      m_acc[k] = 0;
      m_cnt[k] = 0;
      m_sat[k] = 1'b0;
    end else begin
      m_acc[k] = sum;
      m_cnt[k]++;
      m_sat[k] = m_sat[k] | clamp;
    end
  endtask

  task automatic send(input int k, input longint term, input bit fl);
    bit got;
    got        = 1'b0;
    in_valid[k] = 1'b1;
    in_data[k]  = term[36:0];
    flush_s[k]  = fl;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready[k]) begin
        got = 1'b1;
        break;
      end
    end
    check("accept_wait", {63'd0, got}, 64'd1);
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
    flush_s[k]  = 1'b0;
    if (got) model_accept(k, term, fl);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Outputs are compared against the scoreboard head every cycle they are valid; a handshake pops it.
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (reset && out_valid[k]) begin
        vectors++;
        assert (sb.size() != 0 && sb[0].k == k) else begin
          miscompares++;
          $error("FAIL sb_unexpected_out inst=%0d observed=0x%0h expected=none", k, ox[k]);
        end
        if (sb.size() != 0 && sb[0].k == k) begin
          check($sformatf("sb_data%0d", k), {16'd0, ox[k]}, {16'd0, sb[0].d});
          check($sformatf("sb_sat%0d", k), {63'd0, out_sat[k]}, {63'd0, sb[0].s});
          if (out_ready[k]) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    reset     = 1'b0;
    in_valid  = '0;
    flush_s   = '0;
    in_data   = '0;
    out_ready = '1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {60'd0, out_valid}, 64'd0);
    check("rst_in_ready", {60'd0, in_ready}, 64'hF);
    check("rst_term_cnt", {48'd0, tc[0]}, 64'd0);
    check("rst_out_data", {16'd0, ox[0]}, 64'd0);
    check("rst_out_sat", {60'd0, out_sat}, 64'd0);
    reset = 1'b1;
    idle(1);

    // Basic window
    send(0, 10, 0);
    send(0, -3, 0);
    check("t1_cnt_mid", {48'd0, tc[0]}, 64'd2);
    send(0, 7, 0);
    send(0, 100, 0);
    check("t1_valid", {63'd0, out_valid[0]}, 64'd1);
    check("t1_data", {16'd0, ox[0]}, {16'd0, s48(114)});
    check("t1_sat", {63'd0, out_sat[0]}, 64'd0);
    check("t1_cnt_wrap", {48'd0, tc[0]}, 64'd0);
    idle(1);
    check("t1_drained", {63'd0, out_valid[0]}, 64'd0);

    // Output stall holds the result and blocks new terms
    out_ready[0] = 1'b0;
    send(0, 1, 0); send(0, 1, 0); send(0, 1, 0); send(0, 1, 0);
    in_valid[0] = 1'b1;
    in_data[0]  = 37'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_stall_ready", {63'd0, in_ready[0]}, 64'd0);
      check("t2_stall_data", {16'd0, ox[0]}, {16'd0, s48(4)});
      check("t2_stall_cnt", {48'd0, tc[0]}, 64'd0);
    end
    @(posedge clk);
    #1;
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("t2_release_ready", {63'd0, in_ready[0]}, 64'd1);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    model_accept(0, 5, 0);
    check("t2_valid_drop", {63'd0, out_valid[0]}, 64'd0);
    check("t2_cnt_after", {48'd0, tc[0]}, 64'd1);
    send(0, 0, 0); send(0, 0, 0); send(0, 0, 0);
    idle(2);

    // Wide accumulator, large terms: no clamp at ACC_W=40
    for (int i = 0; i < 4; i++) send(1, P36M1, 0);
    check("t3_a40_data", {16'd0, ox[1]}, {16'd0, s48(4 * P36M1)});
    check("t3_a40_sat", {63'd0, out_sat[1]}, 64'd0);
    idle(2);

    // Positive saturation, clean next window, negative boundary, sticky flag
    for (int i = 0; i < 4; i++) send(2, P36M1, 0);
    check("t3_pos_data", {16'd0, ox[2]}, {16'd0, s48(64'sd137438953471)});
    check("t3_pos_sat", {63'd0, out_sat[2]}, 64'd1);
    for (int i = 0; i < 4; i++) send(2, 1, 0);
    check("t3_clean_sat", {63'd0, out_sat[2]}, 64'd0);
    for (int i = 0; i < 4; i++) send(2, N36, 0);
    check("t3_neg_data", {16'd0, ox[2]}, {16'd0, s48(-64'sd137438953472)});
    check("t3_neg_sat", {63'd0, out_sat[2]}, 64'd1);
    for (int i = 0; i < 3; i++) send(2, P36M1, 0);
    send(2, -5, 0);
    idle(2);

    // Flush drops partial window and the flushed term, including a completing one
    send(0, 5, 0); send(0, 5, 0);
    send(0, 5, 1);
    check("t4_flush_cnt", {48'd0, tc[0]}, 64'd0);
    send(0, 1, 0); send(0, 2, 0); send(0, 3, 0); send(0, 4, 0);
    check("t4_data", {16'd0, ox[0]}, {16'd0, s48(10)});
    idle(2);
    send(0, 1, 0); send(0, 1, 0); send(0, 1, 0);
    send(0, 9, 1);
    check("t4_flush_last_valid", {63'd0, out_valid[0]}, 64'd0);
    check("t4_flush_last_cnt", {48'd0, tc[0]}, 64'd0);
    send(0, 3, 0); send(0, 3, 0);

    // LEN=1 streaming then asynchronous reset mid-window / mid-output
    send(3, 7, 0);
    check("t5_out7", {16'd0, ox[3]}, {16'd0, s48(7)});
    send(3, -7, 0);
    check("t5_outm7", {16'd0, ox[3]}, {16'd0, s48(-7)});
    check("t5_valid_cont", {63'd0, out_valid[3]}, 64'd1);
    send(3, 0, 0);
    check("t5_out0", {16'd0, ox[3]}, 64'd0);
    #2;
    reset = 1'b0;
    #1;
    check("t5_rst_valid", {63'd0, out_valid[3]}, 64'd0);
    check("t5_rst_cnt0", {48'd0, tc[0]}, 64'd0);
    check("t5_rst_cnt3", {48'd0, tc[3]}, 64'd0);
    sb.delete();
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(1);
    send(3, 9, 0);
    check("t5_post_rst", {16'd0, ox[3]}, {16'd0, s48(9)});
    send(0, 2, 0); send(0, 2, 0); send(0, 2, 0); send(0, 2, 0);
    check("t5_post_rst_acc", {16'd0, ox[0]}, {16'd0, s48(8)});
    idle(3);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
